// File: rtl/counter_dispatcher_if.sv
// Arrival, counter-feedback and dispatch bus bundle for counter_dispatcher.
// master = arrival/counter side, slave = dispatcher.
interface counter_dispatcher_if #(
    parameter int unsigned DT_SZ   = 4,
    parameter int unsigned N_CTR   = 4,
    parameter int unsigned Q_DEPTH = 8
);
    localparam int unsigned CW = $clog2(Q_DEPTH) + 1;

    logic             arr;
    logic [DT_SZ-1:0] arr_t;
    logic             hold;
    logic [N_CTR-1:0] busy;
    logic [N_CTR-1:0] ld;
    logic [DT_SZ-1:0] dn;
    logic [DT_SZ-1:0] dt;
    logic             full;
    logic             empty;
    logic [CW-1:0]    q_cnt;
    logic             drop;
    logic [DT_SZ-1:0] last_tk;

    modport master (
        output arr, arr_t, hold, busy,
        input  ld, dn, dt, full, empty, q_cnt, drop, last_tk
    );

    modport slave (
        input  arr, arr_t, hold, busy,
        output ld, dn, dt, full, empty, q_cnt, drop, last_tk
    );
endinterface

// File: rtl/counter_dispatcher.sv
// Ticketing FIFO and dispatcher feeding a bank of N_CTR service counters.
// Define ROUND_ROBIN_EN for round-robin counter selection; default is fixed priority.
module counter_dispatcher #(
    parameter int unsigned DT_SZ   = 4,
    parameter int unsigned N_CTR   = 4,
    parameter int unsigned Q_DEPTH = 8
) (
    input logic                 clk,
    input logic                 rst,
    counter_dispatcher_if.slave bus
);
    localparam int unsigned AW = $clog2(Q_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = $clog2(N_CTR);
    localparam logic [DT_SZ-1:0] TK_MAX = '1;

    typedef enum logic {IDLE, ISSUE} sel_state_t;

    sel_state_t       state;
    sel_state_t       state_nxt;

    logic [DT_SZ-1:0] mem_tk [Q_DEPTH];
    logic [DT_SZ-1:0] mem_t  [Q_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_nxt;
    logic [DT_SZ-1:0] tk;
    logic [N_CTR-1:0] claim;
    logic [N_CTR-1:0] issued;
    logic [N_CTR-1:0] elig;
    logic [IW-1:0]    cand;
    logic [IW-1:0]    sel_idx;
    logic             sel_vld;
    logic             pop;
    logic             push;

`ifdef ROUND_ROBIN_EN
    logic [IW-1:0]    rr_ptr;
`endif

    // A load already on the bus masks its counter until the claim register catches it.
    assign issued = (state == ISSUE) ? bus.ld : '0;
    assign elig   = ~bus.busy & ~claim & ~issued;
    assign push   = bus.arr && (bus.arr_t != '0) && (!bus.full || pop);

    // Counter selection and selector next state
    always_comb begin
        state_nxt = IDLE;
        sel_idx   = '0;
        sel_vld   = 1'b0;
        cand      = '0;
        pop       = 1'b0;
        for (int unsigned i = 0; i < N_CTR; i++) begin
`ifdef ROUND_ROBIN_EN
            cand = IW'((32'(rr_ptr) + 32'd1 + i) % N_CTR);
`else
            cand = IW'(i);
`endif
            if (!sel_vld && elig[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
        pop = sel_vld && !bus.empty && !bus.hold;
        if (pop) begin
            state_nxt = ISSUE;
        end
    end

    always_comb begin
        cnt_nxt = bus.q_cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = bus.q_cnt + CW'(1);
            2'b01:   cnt_nxt = bus.q_cnt - CW'(1);
            default: cnt_nxt = bus.q_cnt;
        endcase
    end

    // Entry storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_tk[wr_ptr] <= tk;
            mem_t[wr_ptr]  <= bus.arr_t;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tk          <= DT_SZ'(1);
            claim       <= '0;
            bus.q_cnt   <= '0;
            bus.full    <= 1'b0;
            bus.empty   <= 1'b1;
            bus.drop    <= 1'b0;
            bus.last_tk <= '0;
            bus.ld      <= '0;
            bus.dn      <= '0;
            bus.dt      <= '0;
        end else begin
            state     <= state_nxt;
            claim     <= (claim | issued) & ~bus.busy;
            bus.q_cnt <= cnt_nxt;
            bus.full  <= (cnt_nxt == CW'(Q_DEPTH));
            bus.empty <= (cnt_nxt == '0);
            bus.drop  <= bus.arr && !push;
            if (push) begin
                wr_ptr      <= wr_ptr + AW'(1);
                tk          <= (tk == TK_MAX) ? DT_SZ'(1) : tk + DT_SZ'(1);
                bus.last_tk <= tk;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                bus.ld <= N_CTR'(1) << sel_idx;
                bus.dn <= mem_tk[rd_ptr];
                bus.dt <= mem_t[rd_ptr];
            end else begin
                bus.ld <= '0;
                bus.dn <= '0;
                bus.dt <= '0;
            end
        end
    end

`ifdef ROUND_ROBIN_EN
    // Reset value makes the first search begin at counter 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= IW'(N_CTR - 1);
        end else if (pop) begin
            rr_ptr <= sel_idx;
        end
    end
`endif

endmodule
